// File: rtl/lcd_sequencer_if.sv
// lcd_sequencer_if: requester (host, status writer) and bus-cycle engine signals; slave=sequencer view, master=environment view
interface lcd_sequencer_if;
  logic host_req, host_write, host_rs, host_ack;
  logic [7:0] host_wdata, host_rdata;
  logic stat_req, stat_rs, stat_ack;
  logic [7:0] stat_wdata;
  logic cyc_req, cyc_write, cyc_rs, cyc_done;
  logic [7:0] cyc_wdata, cyc_rdata;
  modport slave (
    input host_req, host_write, host_rs, host_wdata, stat_req, stat_rs, stat_wdata, cyc_done, cyc_rdata,
    output host_ack, host_rdata, stat_ack, cyc_req, cyc_write, cyc_rs, cyc_wdata
  );
  modport master (
    output host_req, host_write, host_rs, host_wdata, stat_req, stat_rs, stat_wdata, cyc_done, cyc_rdata,
    input host_ack, host_rdata, stat_ack, cyc_req, cyc_write, cyc_rs, cyc_wdata
  );
endinterface

// File: rtl/lcd_sequencer.sv
// lcd_sequencer: HD44780 power-up init, then busy-polled round-robin host/stat transfers to the bus-cycle engine; ports clk, rst, bus (requesters+engine), ready, err
module lcd_sequencer #(
  parameter int PWRUP_CYCLES = 750000,
  parameter int INIT_GAP_CYCLES = 250000,
  parameter int POLL_LIMIT = 1023
) (
  input  logic clk,
  input  logic rst,
  lcd_sequencer_if.slave bus,
  output logic ready,
  output logic err
);
  localparam int WMAX = PWRUP_CYCLES > INIT_GAP_CYCLES ? PWRUP_CYCLES : INIT_GAP_CYCLES;
  localparam int CW = $clog2(WMAX + 1);
  localparam int PW = $clog2(POLL_LIMIT + 1);
  typedef enum logic [2:0] {PWR_WAIT, INIT_ISSUE, INIT_GAP, IDLE, POLL, XFER, ACK} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] poll_q, poll_d;
  logic [2:0] idx_q, idx_d;
  logic last_host_q, last_host_d, gnt_host_q, gnt_host_d;
  logic lat_write_q, lat_write_d, lat_rs_q, lat_rs_d;
  logic [7:0] lat_wdata_q, lat_wdata_d;
  logic cyc_req_q, cyc_req_d, cyc_write_q, cyc_write_d, cyc_rs_q, cyc_rs_d;
  logic [7:0] cyc_wdata_q, cyc_wdata_d, rdata_q, rdata_d;
  logic ready_q, ready_d, err_q, err_d;
  logic [7:0] rom;
  logic done, pick_host;
  assign rom = idx_q == 3'd3 ? 8'h08 : idx_q == 3'd4 ? 8'h01 : idx_q == 3'd5 ? 8'h06 : idx_q == 3'd6 ? 8'h0C : 8'h38;
  assign done = cyc_req_q && bus.cyc_done;
  assign pick_host = bus.host_req && (!bus.stat_req || !last_host_q);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    poll_d = state_q == POLL ? poll_q : '0;
    idx_d = idx_q;
    last_host_d = last_host_q;
    gnt_host_d = gnt_host_q;
    lat_write_d = lat_write_q;
    lat_rs_d = lat_rs_q;
    lat_wdata_d = lat_wdata_q;
    cyc_req_d = done ? 1'b0 : cyc_req_q;
    cyc_write_d = cyc_write_q;
    cyc_rs_d = cyc_rs_q;
    cyc_wdata_d = cyc_wdata_q;
    rdata_d = rdata_q;
    ready_d = ready_q;
    err_d = err_q;
    if ((state_q == INIT_ISSUE || state_q == POLL || state_q == XFER) && !cyc_req_q) begin
      cyc_req_d = 1'b1;
      cyc_write_d = state_q != POLL && (!ready_q || lat_write_q);
      cyc_rs_d = state_q == XFER && ready_q && lat_rs_q;
      cyc_wdata_d = state_q == POLL ? 8'h00 : (state_q == XFER && ready_q) ? lat_wdata_q : rom;
    end
    case (state_q)
      PWR_WAIT:
        if (cnt_q == CW'(PWRUP_CYCLES - 1)) begin
          state_d = INIT_ISSUE;
          cyc_req_d = 1'b1;
          cyc_write_d = 1'b1;
          cyc_rs_d = 1'b0;
          cyc_wdata_d = rom;
        end else cnt_d = cnt_q + CW'(1);
      INIT_ISSUE:
        if (done) begin
          state_d = INIT_GAP;
          cnt_d = '0;
        end
      INIT_GAP:
        if (cnt_q == CW'(INIT_GAP_CYCLES - 1)) begin
          idx_d = idx_q + 3'd1;
          state_d = idx_q == 3'd2 ? POLL : INIT_ISSUE;
        end else cnt_d = cnt_q + CW'(1);
      IDLE:
        if (bus.host_req || bus.stat_req) begin
          state_d = POLL;
          gnt_host_d = pick_host;
          last_host_d = pick_host;
          lat_write_d = pick_host ? bus.host_write : 1'b1;
          lat_rs_d = pick_host ? bus.host_rs : bus.stat_rs;
          lat_wdata_d = pick_host ? bus.host_wdata : bus.stat_wdata;
        end
      POLL:
        if (done) begin
          if (!bus.cyc_rdata[7] || poll_q == PW'(POLL_LIMIT - 1)) begin
            state_d = XFER;
            err_d = err_q || bus.cyc_rdata[7];
          end else poll_d = poll_q + PW'(1);
        end
      XFER:
        if (done) begin
          if (ready_q) begin
            state_d = ACK;
            rdata_d = (gnt_host_q && !lat_write_q) ? bus.cyc_rdata : rdata_q;
          end else if (idx_q == 3'd6) begin
            state_d = IDLE;
            ready_d = 1'b1;
          end else begin
            idx_d = idx_q + 3'd1;
            state_d = POLL;
          end
        end
      ACK: state_d = IDLE;
      default: state_d = PWR_WAIT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PWR_WAIT;
      cnt_q <= '0;
      poll_q <= '0;
      idx_q <= '0;
      last_host_q <= 1'b0;
      gnt_host_q <= 1'b0;
      lat_write_q <= 1'b0;
      lat_rs_q <= 1'b0;
      lat_wdata_q <= '0;
      cyc_req_q <= 1'b0;
      cyc_write_q <= 1'b0;
      cyc_rs_q <= 1'b0;
      cyc_wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      poll_q <= poll_d;
      idx_q <= idx_d;
      last_host_q <= last_host_d;
      gnt_host_q <= gnt_host_d;
      lat_write_q <= lat_write_d;
      lat_rs_q <= lat_rs_d;
      lat_wdata_q <= lat_wdata_d;
      cyc_req_q <= cyc_req_d;
      cyc_write_q <= cyc_write_d;
      cyc_rs_q <= cyc_rs_d;
      cyc_wdata_q <= cyc_wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q <= err_d;
    end
  end
  assign bus.host_ack = state_q == ACK && gnt_host_q;
  assign bus.stat_ack = state_q == ACK && !gnt_host_q;
  assign bus.host_rdata = rdata_q;
  assign bus.cyc_req = cyc_req_q;
  assign bus.cyc_write = cyc_write_q;
  assign bus.cyc_rs = cyc_rs_q;
  assign bus.cyc_wdata = cyc_wdata_q;
  assign ready = ready_q;
  assign err = err_q;
endmodule

// File: doc/lcd_sequencer.md
Name: lcd_sequencer

Overview:
- Sits between the LCD bus-cycle engine and two command sources: the SPI host path and the local GPSDO status writer.
- After reset it runs the HD44780 power-up initialisation autonomously, then arbitrates round-robin between the two requesters.
- Every requested transfer is preceded by busy-flag polling, so neither requester deals with LCD timing.

Parameters:
- PWRUP_CYCLES, 750000: clk cycles to wait after reset before the first command (15 ms at 50 MHz).
- INIT_GAP_CYCLES, 250000: fixed wait after each of the three initial function-set commands (5 ms).
- POLL_LIMIT, 1023: maximum busy-flag reads per transfer before declaring a timeout.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- host_req  in  1  host request; held with its fields until host_ack
- host_write  in  1  1=write, 0=read
- host_rs  in  1  register select, 0=command/status, 1=data
- host_wdata  in  8  host write data
- host_ack  out  1  one-cycle pulse when the host transfer completes
- host_rdata  out  8  read result; valid while host_ack=1, held until the next host read
- stat_req  in  1  status-writer request (write-only); held until stat_ack
- stat_rs  in  1  register select
- stat_wdata  in  8  write data
- stat_ack  out  1  one-cycle completion pulse
- cyc_req  out  1  bus-cycle request to the engine; held until cyc_done
- cyc_write  out  1  1=write cycle, 0=read cycle
- cyc_rs  out  1  RS for the cycle
- cyc_wdata  out  8  write data for the cycle
- cyc_done  in  1  one-cycle pulse from the engine at end of cycle
- cyc_rdata  in  8  read data; valid when cyc_done=1
- ready  out  1  initialisation complete
- err  out  1  sticky busy-poll timeout flag

Behaviour:
- Reset values: all outputs 0, host_rdata=0x00; state PWR_WAIT; counters 0; last_grant=STAT, so the host wins the first tie. Reset mid-operation aborts immediately: cyc_req=0 on the next edge and the full init sequence reruns.
- Engine handshake: cyc_req, cyc_write, cyc_rs and cyc_wdata are registered and stable while cyc_req=1. On the edge sampling cyc_done=1, cyc_req drops. A new cycle is never issued in the same cycle that cyc_done is sampled.
- States: PWR_WAIT, INIT_ISSUE, INIT_GAP, IDLE, POLL, XFER, ACK.
- PWR_WAIT: count PWRUP_CYCLES, then go to INIT_ISSUE with idx=0.
- Init ROM, idx 0..6: 0x38, 0x38, 0x38, 0x08, 0x01, 0x06, 0x0C. All entries are cyc_write=1, cyc_rs=0.
  - idx 0-2: issue the write; on done go to INIT_GAP for INIT_GAP_CYCLES, then idx+1.
  - idx 3-6: go through POLL then XFER, same as requester transfers.
  - After the idx 6 done: ready=1 (stays 1 until rst), state IDLE.
- Requests are ignored until ready=1; host_ack and stat_ack stay 0 during init.
- IDLE:
  - One request asserted: grant it.
  - Both asserted: grant the one not equal to last_grant.
  - On grant: latch write/rs/wdata (stat is always write=1), update last_grant, enter POLL. cyc_req rises in the cycle after the grant edge.
- POLL: read cycle (cyc_write=0, cyc_rs=0). On done:
  - cyc_rdata[7]=0: go to XFER.
  - Otherwise increment poll_cnt and reissue after one idle cycle.
  - If poll_cnt reaches POLL_LIMIT: set err=1 (sticky until rst) and go to XFER anyway.
  - poll_cnt clears on entry to POLL.
- XFER: issue the latched cycle. On done, if it is a host read, capture cyc_rdata into host_rdata. Then go to ACK.
- ACK: pulse the granted requester's ack for exactly one cycle, then IDLE. The requester must drop req, or present a new request, by the cycle after ack. A req still high in IDLE is treated as a new request.
- Counter widths: sized by $clog2 of each parameter+1. Comparisons are equality against the parameter; no wrap-around is possible.

Test Plan:
- Init sequence (PWRUP_CYCLES=10, INIT_GAP_CYCLES=4, engine returns cyc_rdata=0x00, done 3 cycles after req):
  - first cyc_req 10 cycles after rst release;
  - writes 0x38, 0x38, 0x38 with ≥4-cycle gaps;
  - then read/write pairs for 0x08, 0x01, 0x06, 0x0C;
  - then ready=1, err=0.
- Simultaneous host_req (write rs=1, 0x41) and stat_req (rs=1, 0x42) after ready:
  - host is granted first;
  - order of write cycles is 0x41 then 0x42;
  - host_ack and stat_ack each pulse once.
- Busy polling: engine returns BF=1 (0x80) on two reads, then 0x00 → exactly 3 status reads precede the data write; err=0.
- Timeout (POLL_LIMIT=3): BF stuck at 0x80 → 3 reads, err=1, write still issued, ack pulses, err stays 1 across later transfers.
- Host read (host_write=0, host_rs=1): engine returns 0x5A on the XFER cycle → host_rdata=0x5A in the host_ack cycle and held afterward.
- Reset mid-operation: assert rst while cyc_req=1 during XFER → cyc_req=0 and ready=0 after the next edge, no ack pulse; after release the init sequence restarts from PWR_WAIT.
